// File: rtl/mlp_epoch_sequencer.sv
// mlp_epoch_sequencer: holds a small training set and plays it into an MLP for a
// programmed number of epochs (one train pass then one eval pass per epoch),
// thresholds the eval-pass predictions and reports a per-epoch correct count.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   load_en_i/load_idx_i/load_*_i    sample memory write port (IDLE only)
//   num_samples_i/num_epochs_i       run configuration, latched on start_i
//   threshold_i                      signed class threshold, latched on start_i
//   start_i                          run request (IDLE only)
//   values_o/expected_o/training_o   stimulus towards the MLP
//   prediction_i                     MLP prediction, PRED_LATENCY cycles after values_o
//   busy_o/done_o                    run in progress / end-of-run pulse
//   epoch_o/epoch_valid_o/epoch_correct_o  epoch index and per-epoch score report
module mlp_epoch_sequencer #(
   parameter int unsigned INPUTS       = 2,
   parameter int unsigned OUTPUTS      = 1,
   parameter int unsigned SAMPLES      = 4,
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned FRAC_W       = 32,
   parameter int unsigned PRED_LATENCY = 1,
   parameter int unsigned EPOCH_W      = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          load_en_i,
   input  logic [$clog2(SAMPLES)-1:0]    load_idx_i,
   input  logic [INPUTS*DATA_W-1:0]      load_values_i,
   input  logic [OUTPUTS*DATA_W-1:0]     load_expected_i,
   input  logic [$clog2(SAMPLES+1)-1:0]  num_samples_i,
   input  logic [EPOCH_W-1:0]            num_epochs_i,
   input  logic [DATA_W-1:0]             threshold_i,
   input  logic                          start_i,
   output logic [INPUTS*DATA_W-1:0]      values_o,
   output logic [OUTPUTS*DATA_W-1:0]     expected_o,
   output logic                          training_o,
   input  logic [OUTPUTS*DATA_W-1:0]     prediction_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [EPOCH_W-1:0]            epoch_o,
   output logic                          epoch_valid_o,
   output logic [$clog2(SAMPLES+1)-1:0]  epoch_correct_o
);

   localparam int unsigned IDX_W = $clog2(SAMPLES);
   localparam int unsigned CNT_W = $clog2(SAMPLES + 1);
   localparam int unsigned VAL_W = INPUTS * DATA_W;
   localparam int unsigned EXP_W = OUTPUTS * DATA_W;
   localparam int unsigned DRN_W = $clog2(PRED_LATENCY + 1);
   localparam int unsigned EPW1  = EPOCH_W + 1;

   // Reject configurations the datapath cannot represent.
   if (FRAC_W >= DATA_W || PRED_LATENCY < 1 || SAMPLES < 2) begin : g_cfg_check
      $error("mlp_epoch_sequencer: unsupported parameter set");
   end

   typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_EVAL, S_DRAIN} state_e;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DRN_W-1:0]     drn_q, drn_d;
   logic [CNT_W-1:0]     n_q, n_d;
   logic [EPOCH_W-1:0]   ep_num_q, ep_num_d;
   logic [DATA_W-1:0]    thr_q, thr_d;
   logic [CNT_W-1:0]     acc_q, acc_d;
   logic [VAL_W-1:0]     values_q, values_d;
   logic [EXP_W-1:0]     expected_q, expected_d;
   logic                 training_q, training_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [EPOCH_W-1:0]   epoch_q, epoch_d;
   logic                 valid_q, valid_d;
   logic [CNT_W-1:0]     correct_q, correct_d;

   logic [VAL_W-1:0]     mem_val_q [SAMPLES];
   logic [EXP_W-1:0]     mem_exp_q [SAMPLES];
   logic [PRED_LATENCY-1:0] tag_vld_q;
   logic [EXP_W-1:0]     tag_exp_q [PRED_LATENCY];

   logic                 load_wr;
   logic [CNT_W-1:0]     ns_clamp;
   logic                 last_idx;
   logic                 match;
   logic                 hit;
   logic                 more_epochs;

   assign load_wr     = load_en_i && (state_q == S_IDLE);
   assign ns_clamp    = (num_samples_i > CNT_W'(SAMPLES)) ? CNT_W'(SAMPLES) : num_samples_i;
   assign last_idx    = (CNT_W'(idx_q) == (n_q - CNT_W'(1)));
   assign more_epochs = ((EPW1'(epoch_q) + EPW1'(1)) < EPW1'(ep_num_q));

   // Sample memory: not reset, writable only while idle.
   always_ff @(posedge clk_i) begin
      if (load_wr) begin
         mem_val_q[load_idx_i] <= load_values_i;
         mem_exp_q[load_idx_i] <= load_expected_i;
      end
   end

   // Scoring: the tag that left EVAL PRED_LATENCY cycles ago meets the current prediction.
   always_comb begin
      match = 1'b1;
      for (int o = 0; o < OUTPUTS; o++) begin
         if (($signed(prediction_i[o*DATA_W +: DATA_W]) < $signed(thr_q)) !=
             ($signed(tag_exp_q[PRED_LATENCY-1][o*DATA_W +: DATA_W]) < $signed(thr_q))) begin
            match = 1'b0;
         end
      end
      hit = tag_vld_q[PRED_LATENCY-1] && match;
   end

   // Next state and next registered outputs.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      drn_d      = drn_q;
      n_d        = n_q;
      ep_num_d   = ep_num_q;
      thr_d      = thr_q;
      acc_d      = acc_q + CNT_W'(hit);
      epoch_d    = epoch_q;
      correct_d  = correct_q;
      done_d     = 1'b0;
      valid_d    = 1'b0;
      values_d   = '0;
      expected_d = '0;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               n_d      = ns_clamp;
               ep_num_d = num_epochs_i;
               thr_d    = threshold_i;
               if (ns_clamp == '0 || num_epochs_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_TRAIN;
                  idx_d   = '0;
                  epoch_d = '0;
                  acc_d   = '0;
               end
            end
         end
         S_TRAIN: begin
            if (last_idx) begin
               state_d = S_EVAL;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_EVAL: begin
            if (last_idx) begin
               state_d = S_DRAIN;
               drn_d   = '0;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_DRAIN: begin
            if (drn_q == DRN_W'(PRED_LATENCY - 1)) begin
               // Last prediction of the pass lands this cycle: report and roll over.
               valid_d   = 1'b1;
               correct_d = acc_q + CNT_W'(hit);
               acc_d     = '0;
               if (more_epochs) begin
                  epoch_d = epoch_q + EPOCH_W'(1);
                  state_d = S_TRAIN;
                  idx_d   = '0;
               end else begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else begin
               drn_d = drn_q + DRN_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d     = (state_d != S_IDLE);
      training_d = (state_d == S_TRAIN);
      if (state_d == S_TRAIN || state_d == S_EVAL) begin
         // Bypass a same-cycle idle write so a run started with a load sees the new data.
         if (load_wr && load_idx_i == idx_d) begin
            values_d   = load_values_i;
            expected_d = load_expected_i;
         end else begin
            values_d   = mem_val_q[idx_d];
            expected_d = mem_exp_q[idx_d];
         end
      end
   end

   // State, configuration and output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         drn_q      <= '0;
         n_q        <= '0;
         ep_num_q   <= '0;
         thr_q      <= '0;
         acc_q      <= '0;
         values_q   <= '0;
         expected_q <= '0;
         training_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         epoch_q    <= '0;
         valid_q    <= 1'b0;
         correct_q  <= '0;
         tag_vld_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         drn_q      <= drn_d;
         n_q        <= n_d;
         ep_num_q   <= ep_num_d;
         thr_q      <= thr_d;
         acc_q      <= acc_d;
         values_q   <= values_d;
         expected_q <= expected_d;
         training_q <= training_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         epoch_q    <= epoch_d;
         valid_q    <= valid_d;
         correct_q  <= correct_d;
         for (int i = PRED_LATENCY - 1; i > 0; i--) begin
            tag_vld_q[i] <= tag_vld_q[i-1];
         end
         tag_vld_q[0] <= (state_q == S_EVAL);
      end
   end

   // Expected-value half of the scoring tag; qualified by tag_vld_q.
   always_ff @(posedge clk_i) begin
      for (int i = PRED_LATENCY - 1; i > 0; i--) begin
         tag_exp_q[i] <= tag_exp_q[i-1];
      end
      tag_exp_q[0] <= expected_q;
   end

   assign values_o        = values_q;
   assign expected_o      = expected_q;
   assign training_o      = training_q;
   assign busy_o          = busy_q;
   assign done_o          = done_q;
   assign epoch_o         = epoch_q;
   assign epoch_valid_o   = valid_q;
   assign epoch_correct_o = correct_q;

endmodule

// File: tb/tb_mlp_epoch_sequencer.sv
// Directed bench for mlp_epoch_sequencer with a stub MLP and stimulus/score scoreboards.
module tb_mlp_epoch_sequencer;

   localparam logic signed [63:0] ONE  = 64'sh0000_0001_0000_0000;
   localparam logic signed [63:0] HALF = 64'sh0000_0000_8000_0000;

   typedef struct packed {
      logic         trn;
      logic [127:0] v;
      logic [63:0]  e;
      logic [15:0]  ep;
   } stim_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         load_en;
   logic [1:0]   load_idx;
   logic [127:0] load_values;
   logic [63:0]  load_expected;
   logic [2:0]   num_samples;
   logic [15:0]  num_epochs;
   logic [63:0]  threshold;
   logic         start;
   logic [127:0] values;
   logic [63:0]  expected;
   logic         training;
   logic [63:0]  prediction = '0;
   logic         busy;
   logic         done;
   logic [15:0]  epoch;
   logic         epoch_valid;
   logic [2:0]   epoch_correct;

   int checks   = 0;
   int failures = 0;

   int                 mode = 0;
   logic signed [63:0] pred_const = '0;
   logic [127:0]       tv [4];
   logic signed [63:0] te [4];
   stim_t              stim_q [$];
   logic [2:0]         corr_q [$];

   mlp_epoch_sequencer dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .load_en_i       (load_en),
      .load_idx_i      (load_idx),
      .load_values_i   (load_values),
      .load_expected_i (load_expected),
      .num_samples_i   (num_samples),
      .num_epochs_i    (num_epochs),
      .threshold_i     (threshold),
      .start_i         (start),
      .values_o        (values),
      .expected_o      (expected),
      .training_o      (training),
      .prediction_i    (prediction),
      .busy_o          (busy),
      .done_o          (done),
      .epoch_o         (epoch),
      .epoch_valid_o   (epoch_valid),
      .epoch_correct_o (epoch_correct)
   );

   always #5 clk = ~clk;

   // Stub MLP with one cycle of prediction latency.
   always @(posedge clk) begin
      case (mode)
         0:       prediction <= expected;
         1:       prediction <= ONE - expected;
         default: prediction <= pred_const;
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] model_corr(input int n, input logic signed [63:0] thr);
      int c = 0;
      logic signed [63:0] p;
      for (int k = 0; k < n; k++) begin
         p = (mode == 0) ? te[k] : (mode == 1) ? (ONE - te[k]) : pred_const;
         if ((p < thr) == (te[k] < thr)) c++;
      end
      return 3'(c);
   endfunction

   task automatic load(input int idx, input logic signed [63:0] in0, input logic signed [63:0] in1,
                       input logic signed [63:0] ex);
      load_en = 1'b1; load_idx = 2'(idx);
      load_values = {in1, in0}; load_expected = ex;
      tv[idx] = {in1, in0}; te[idx] = ex;
      step();
      load_en = 1'b0;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_values"},   values, '0);
      chk({tag, "_expected"}, 128'(expected), '0);
      chk({tag, "_training"}, 128'(training), '0);
      chk({tag, "_busy"},     128'(busy), '0);
      chk({tag, "_valid"},    128'(epoch_valid), '0);
   endtask

   // Start a run, push the expected stimulus and scores, then follow it to done.
   task automatic run(input int ns_in, input int n_eff, input int eps,
                      input logic signed [63:0] thr, input bit disturb);
      stim_t s;
      int busy_cnt = 0;
      int pulses = 0;
      bit finished = 0;
      num_samples = 3'(ns_in); num_epochs = 16'(eps); threshold = thr; start = 1'b1;
      for (int e = 0; e < eps; e++) begin
         for (int ph = 0; ph < 2; ph++)
            for (int k = 0; k < n_eff; k++)
               stim_q.push_back('{trn: (ph == 0), v: tv[k], e: te[k], ep: 16'(e)});
         stim_q.push_back('{trn: 1'b0, v: '0, e: '0, ep: 16'(e)});
         corr_q.push_back(model_corr(n_eff, thr));
      end
      step();
      start = 1'b0;
      for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
         if (busy) begin
            busy_cnt++;
            if (stim_q.size() == 0) chk("stim_extra", 1, 0);
            else begin
               s = stim_q.pop_front();
               chk("training", 128'(training), 128'(s.trn));
               chk("values",   values, s.v);
               chk("expected", 128'(expected), 128'(s.e));
               chk("epoch",    128'(epoch), 128'(s.ep));
            end
         end
         if (epoch_valid) begin
            if (corr_q.size() == 0) chk("valid_extra", 1, 0);
            else begin
               chk("epoch_correct", 128'(epoch_correct), 128'(corr_q.pop_front()));
               pulses++;
               chk("epoch_at_pulse", 128'(epoch), 128'((pulses < eps) ? pulses : eps - 1));
               chk("done_with_last", 128'(done), 128'(pulses == eps));
            end
         end else if (done) begin
            chk("done_without_valid", 1, 0);
         end
         if (done) finished = 1;
         if (disturb && busy_cnt == 3) begin
            load_en = 1'b1; load_idx = 2'd0; load_values = '1; load_expected = '1; start = 1'b1;
         end else begin
            load_en = 1'b0; start = 1'b0;
         end
         step();
      end
      chk("run_finished", 128'(finished), 1);
      chk("busy_cycles", 128'(busy_cnt), 128'((2 * n_eff + 1) * eps));
      chk("done_pulse_width", 128'(done), 0);
      chk("stim_left", 128'(stim_q.size()), 0);
      chk("corr_left", 128'(corr_q.size()), 0);
      stim_q.delete();
      corr_q.delete();
   endtask

   initial begin
      rst = 1'b1; load_en = 1'b0; load_idx = '0; load_values = '0; load_expected = '0;
      num_samples = '0; num_epochs = '0; threshold = '0; start = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      chk_idle_outputs("reset");
      chk("reset_done",    128'(done), 0);
      chk("reset_epoch",   128'(epoch), 0);
      chk("reset_correct", 128'(epoch_correct), 0);

      // XOR training set
      load(0, 0, 0, 0);
      load(1, 0, ONE, ONE);
      load(2, ONE, 0, ONE);
      load(3, ONE, ONE, 0);

      mode = 0; run(4, 4, 2, HALF, 0);       // perfect predictor
      mode = 1; run(4, 4, 2, HALF, 0);       // inverted predictor
      mode = 2; pred_const = HALF;
      run(4, 4, 1, HALF, 0);                 // prediction exactly at threshold
      mode = 0; run(7, 4, 1, HALF, 0);       // sample count clamped
      run(4, 4, 2, HALF, 1);                 // load/start while busy ignored
      run(2, 2, 3, HALF, 0);                 // shorter pass, three epochs

      // load and start in the same idle cycle
      load_en = 1'b1; load_idx = 2'd3; load_values = {ONE, ONE}; load_expected = ONE;
      tv[3] = {ONE, ONE}; te[3] = ONE;
      run(4, 4, 1, HALF, 0);
      load(3, ONE, ONE, 0);

      // zero epochs / zero samples: done only
      for (int z = 0; z < 2; z++) begin
         num_samples = (z == 0) ? 3'd4 : 3'd0;
         num_epochs  = (z == 0) ? 16'd0 : 16'd2;
         start = 1'b1;
         step();
         start = 1'b0;
         chk("zero_done", 128'(done), 1);
         chk_idle_outputs("zero_run");
         step();
         chk("zero_done_drop", 128'(done), 0);
         chk("zero_busy_later", 128'(busy), 0);
      end

      // reset during the second eval cycle
      num_samples = 3'd4; num_epochs = 16'd2; threshold = HALF; start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      chk("pre_reset_eval", 128'(training), 0);
      chk("pre_reset_busy", 128'(busy), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle_outputs("mid_reset");
      chk("mid_reset_done", 128'(done), 0);
      repeat (3) begin
         step();
         chk("post_reset_done", 128'(done), 0);
         chk("post_reset_busy", 128'(busy), 0);
      end
      run(4, 4, 1, HALF, 0);                 // memory retained across reset

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
